// File: rtl/addr_seq_counter.sv
// addr_seq_counter: start/end address sequencer with up/down wrap-around counting.
module addr_seq_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] start_addr,
  input  logic [WIDTH-1:0] end_addr,
  input  logic             dir,
  input  logic             inc,
  input  logic             abort,
  output logic [WIDTH-1:0] addr,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state;
  logic [WIDTH-1:0] end_q;
  logic dir_q;
  assign busy = state == RUN;
  assign done = state == FINISH;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      end_q <= '0;
      dir_q <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            addr <= start_addr;
            end_q <= end_addr;
            dir_q <= dir;
            state <= RUN;
          end
        RUN:
          if (abort) state <= IDLE;
          else if (inc) begin
            if (addr == end_q) state <= FINISH;
            else addr <= dir_q ? addr - WIDTH'(1) : addr + WIDTH'(1);
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_addr_seq_counter.sv
// tb_addr_seq_counter: directed vector table, reset corner case and randomized model check.
module tb_addr_seq_counter;
  localparam int W = 2;
  localparam int M = (1 << W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dir = 1'b0, inc = 1'b0, abort = 1'b0;
  logic [W-1:0] start_addr = '0, end_addr = '0, addr;
  logic busy, done;
  int total = 0, bad = 0;
  int m_phase, m_base, m_k, m_n, m_dir, m_addr;

  typedef struct {
    logic st; logic [W-1:0] sa; logic [W-1:0] ea; logic dr; logic in; logic ab;
    logic [W-1:0] x_addr; logic x_busy; logic x_done;
  } vec_t;
  vec_t vt[$];

  addr_seq_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .dir(dir), .inc(inc), .abort(abort), .addr(addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input int ea, input int eb, input int ed);
    check({tag, " addr"}, int'(addr), ea);
    check({tag, " busy"}, int'(busy), eb);
    check({tag, " done"}, int'(done), ed);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, input int sa, input int ea, input logic dr, input logic in,
                     input logic ab, input int xa, input logic xb, input logic xd);
    vec_t v;
    v.st = st; v.sa = W'(sa); v.ea = W'(ea); v.dr = dr; v.in = in; v.ab = ab;
    v.x_addr = W'(xa); v.x_busy = xb; v.x_done = xd;
    vt.push_back(v);
  endtask

  // Reference: a run is N+1 accepted increments; address is base +/- increments taken so far.
  task automatic model_edge();
    case (m_phase)
      0: if (start) begin
        m_base = int'(start_addr);
        m_dir = int'(dir);
        m_n = (dir ? int'(start_addr) - int'(end_addr) : int'(end_addr) - int'(start_addr)) & M;
        m_k = 0;
        m_addr = m_base;
        m_phase = 1;
      end
      1: if (abort) m_phase = 0;
        else if (inc) begin
          if (m_k == m_n) m_phase = 2;
          else begin
            m_k++;
            m_addr = (m_dir != 0 ? m_base - m_k : m_base + m_k) & M;
          end
        end
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    #1;
    check_out("reset", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    add(1, 0, 3, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 1, 0, 3, 0, 1);
    add(0, 0, 0, 0, 1, 0, 3, 0, 0);
    add(1, 3, 1, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 2, 1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 3, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 0);
    add(1, 0, 3, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 1, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 2, 0, 0);
    add(0, 0, 0, 0, 0, 1, 2, 0, 0);
    add(1, 1, 3, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 1, 0);
    add(1, 0, 0, 1, 0, 0, 2, 1, 0);
    add(0, 0, 0, 1, 0, 0, 2, 1, 0);
    add(0, 0, 0, 1, 1, 0, 3, 1, 0);
    add(0, 0, 0, 1, 1, 0, 3, 0, 1);
    add(1, 0, 0, 0, 0, 0, 3, 0, 0);
    add(1, 2, 2, 0, 0, 0, 2, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2, 0, 1);
    add(0, 0, 0, 0, 0, 0, 2, 0, 0);
    foreach (vt[i]) begin
      start = vt[i].st; start_addr = vt[i].sa; end_addr = vt[i].ea;
      dir = vt[i].dr; inc = vt[i].in; abort = vt[i].ab;
      step();
      check_out($sformatf("vec%0d", i), int'(vt[i].x_addr), int'(vt[i].x_busy), int'(vt[i].x_done));
    end
    // Asynchronous reset mid-run at addr 2; the sequence must not resume.
    start = 1'b1; start_addr = 0; end_addr = 3; dir = 1'b0; inc = 1'b0; abort = 1'b0;
    step();
    start = 1'b0; inc = 1'b1;
    step();
    step();
    check_out("pre_rst", 2, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 0, 0, 0);
    step();
    check_out("rst_held", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_out("post_rst1", 0, 0, 0);
    step();
    check_out("post_rst2", 0, 0, 0);
    m_phase = 0; m_addr = 0; m_base = 0; m_k = 0; m_n = 0; m_dir = 0;
    for (int i = 0; i < 400; i++) begin
      start = $urandom_range(0, 9) < 3;
      start_addr = W'($urandom);
      end_addr = W'($urandom);
      dir = 1'($urandom);
      inc = $urandom_range(0, 9) < 6;
      abort = $urandom_range(0, 19) == 0;
      model_edge();
      step();
      check_out($sformatf("rnd%0d", i), m_addr, int'(m_phase == 1), int'(m_phase == 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/addr_seq_counter.md
ADDR_SEQ_COUNTER -- requirements
Module: addr_seq_counter

Interface
REQ-001 Parameter WIDTH SHALL have default 2: address width in bits, legal range 1..16.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-004 Start  input  1  request to begin an address sequence; honoured only in IDLE.
REQ-005 StartAddr  input  WIDTH  first address of the sequence, sampled when Start is honoured.
REQ-006 EndAddr  input  WIDTH  last address of the sequence, sampled when Start is honoured.
REQ-007 Dir  input  1  0 = count up, 1 = count down; sampled when Start is honoured.
REQ-008 Inc  input  1  advance request; acted on only in RUN.
REQ-009 Abort  input  1  terminate the current sequence without completion.
REQ-010 Addr  output  WIDTH  current address, registered.
REQ-011 Busy  output  1  high while the FSM is in RUN.
REQ-012 Done  output  1  one-cycle completion pulse, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and FINISH.
REQ-014 In IDLE with Start=1, the next edge SHALL load Addr<=StartAddr, latch EndAddr and Dir internally, and enter RUN.
REQ-015 In IDLE with Start=0, Addr SHALL hold its value.
REQ-016 In RUN with Abort=1, the next edge SHALL enter IDLE with Addr held and no Done pulse; Abort SHALL take priority over Inc.
REQ-017 In RUN with Abort=0, Inc=1 and Addr equal to the latched end address, the next edge SHALL enter FINISH with Addr held.
REQ-018 In RUN with Abort=0, Inc=1 and Addr not equal to the latched end address, Addr SHALL advance by +1 (Dir=0) or -1 (Dir=1), modulo 2^WIDTH.
  - Wrap-around is legal in both directions: up 2^WIDTH-1 -> 0, down 0 -> 2^WIDTH-1.
REQ-019 In RUN with Inc=0 and Abort=0, Addr and the state SHALL hold.
REQ-020 A sequence SHALL require exactly N+1 accepted Inc cycles, where N is the modular distance from StartAddr to EndAddr in the latched direction.
  - StartAddr==EndAddr therefore completes on the first Inc.
REQ-021 In FINISH, Done SHALL be 1 for exactly one cycle, Busy SHALL be 0, and the next edge SHALL enter IDLE unconditionally.
REQ-022 Start SHALL be ignored in RUN and FINISH; Inc and Abort SHALL be ignored in IDLE and FINISH.
REQ-023 Busy SHALL be a direct decode of state==RUN; Done SHALL be a direct decode of state==FINISH.
REQ-024 Changes to StartAddr, EndAddr and Dir after Start is honoured SHALL have no effect on the running sequence.

Reset
REQ-025 While Reset=0, and immediately on assertion without waiting for a clock edge, the outputs SHALL be Addr=0, Busy=0, Done=0; the state SHALL be IDLE and the latched end address and Dir SHALL be 0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no Done pulse.
REQ-027 The first edge after Reset deasserts SHALL be treated as IDLE behaviour.

Verification (WIDTH=2)
REQ-028 The bench SHALL cover: Start, StartAddr=0, EndAddr=3, Dir=0, Inc held high -> Addr 0,1,2,3; Done=1 for one cycle after the 4th Inc; Busy high for 4 cycles.
REQ-029 The bench SHALL cover: StartAddr=3, EndAddr=1, Dir=0, Inc high -> Addr 3,0,1, then Done; wrap verified.
REQ-030 The bench SHALL cover: StartAddr=1, EndAddr=2, Dir=1, Inc high -> Addr 1,0,3,2, then Done.
REQ-031 The bench SHALL cover: Abort=1 together with Inc=1 at Addr=2 -> IDLE, Addr=2, Busy=0, Done never asserted.
REQ-032 The bench SHALL cover: Inc toggled 1,0,0,1 during RUN with Start pulsed mid-run -> Addr advances only on Inc=1 and Start has no effect.
REQ-033 The bench SHALL cover: Reset driven low between edges while Addr=2 in RUN -> Addr=0, Busy=0 asynchronously; the sequence is not resumed after release.
